// File: rtl/decode_fq.sv
// Fetch-to-decode parcel queue: circular buffer of 16-bit parcels with their PCs,
// accepting up to NP parcels per beat and presenting one pre-decoded head parcel.
module decode_fq #(
   parameter int RV    = 32,
   parameter int DEPTH = 4,
   parameter int NP    = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         f_valid,
   output logic                         f_ready,
   input  logic [16*NP-1:0]             f_data,
   input  logic [RV-1:0]                f_pc,
   input  logic                         f_skip,
   input  logic                         flush,
   output logic                         d_valid,
   input  logic                         d_ready,
   output logic [15:0]                  d_ins,
   output logic [RV-1:0]                d_pc,
   output logic                         d_ctl,
   output logic                         d_illegal,
   output logic [$clog2(DEPTH+1)-1:0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   typedef struct packed {
      logic [15:0]   ins;
      logic [RV-1:0] pc;
   } entry_t;

   entry_t          mem [DEPTH];
   logic [AW-1:0]   rd_ptr, wr_ptr;
   logic [CW-1:0]   count_q;
   logic [CW:0]     free_slots;
   logic            skip, push, pop;
   logic [CW-1:0]   n_push;
   logic [RV-1:0]   base_pc;
   entry_t          head;

   // Compressed/full-length control-transfer pre-decode of a single parcel.
   function automatic logic is_ctl(input logic [15:0] i);
      logic r;
      r = 1'b0;
      case (i[1:0])
         2'b00: r = (i[15:14] == 2'b10);
         2'b01: r = (i[15:13] == 3'b001) || (i[15:13] == 3'b101) ||
                    (i[15:14] == 2'b11);
         2'b10: r = (i[15:13] == 3'b100) && (i[6:2] == 5'd0);
         2'b11: r = (i[15:14] == 2'b11);
         default: r = 1'b0;
      endcase
      return r;
   endfunction

   assign free_slots = (CW+1)'(DEPTH) - {1'b0, count_q};
   assign f_ready    = free_slots >= (CW+1)'(NP);
   assign skip       = (NP == 2) && f_skip;
   assign push       = f_valid && f_ready && !flush;
   assign pop        = d_valid && d_ready && !flush;
   assign n_push     = skip ? CW'(1) : CW'(NP);
   assign base_pc    = f_pc & ~RV'(1);

   // Skipped beats shift parcel 1 down into the slot parcel 0 would have used.
   always_ff @(posedge clk) begin
      if (push) begin
         for (int k = 0; k < NP; k++) begin
            if (!(skip && k == 0)) begin
               mem[wr_ptr + AW'(k) - AW'(skip)] <= '{ins: f_data[16*k +: 16],
                                                       pc:  base_pc + RV'(2*k)};
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count_q <= '0;
      end else if (flush) begin
         rd_ptr  <= wr_ptr;
         count_q <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(n_push);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         count_q <= count_q + (push ? n_push : CW'(0)) - CW'(pop);
      end
   end

   assign head      = mem[rd_ptr];
   assign count     = count_q;
   assign d_valid   = (count_q != '0);
   assign d_ins     = head.ins;
   assign d_pc      = head.pc;
   assign d_ctl     = d_valid && is_ctl(head.ins);
   assign d_illegal = d_valid && (head.ins == 16'h0000);
endmodule

// File: tb/tb_decode_fq.sv
// Directed bench for decode_fq (DEPTH=4, NP=2, RV=32) with hand-computed expectations.
module tb_decode_fq;
   logic        clk = 1'b0;
   logic        reset, f_valid, f_ready, f_skip, flush;
   logic [31:0] f_data, f_pc, d_pc;
   logic        d_valid, d_ready, d_ctl, d_illegal;
   logic [15:0] d_ins;
   logic [2:0]  count;

   int n_chk = 0;
   int n_err = 0;

   decode_fq #(.RV(32), .DEPTH(4), .NP(2)) dut (
      .clk(clk), .reset(reset), .f_valid(f_valid), .f_ready(f_ready),
      .f_data(f_data), .f_pc(f_pc), .f_skip(f_skip), .flush(flush),
      .d_valid(d_valid), .d_ready(d_ready), .d_ins(d_ins), .d_pc(d_pc),
      .d_ctl(d_ctl), .d_illegal(d_illegal), .count(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Sequential parcel n carries ins 16'h1000+n at pc 32'h300+2n.
   task automatic chk_head(input int n);
      chk("head_ins", 64'(d_ins), 64'(16'h1000 + n));
      chk("head_pc",  64'(d_pc),  64'(32'h300 + 2*n));
   endtask

   task automatic set_beat(input int n);
      f_valid = 1'b1;
      f_data  = {16'(16'h1000 + n + 1), 16'(16'h1000 + n)};
      f_pc    = 32'h300 + 32'(2*n);
   endtask

   task automatic pop1();
      d_ready = 1'b1;
      step();
      d_ready = 1'b0;
   endtask

   logic [15:0] ctl_p [6] = '{16'h8082, 16'h8086, 16'hC0EF, 16'h0063, 16'hA000, 16'h6000};
   logic        ctl_e [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

   initial begin
      reset = 1'b1; f_valid = 1'b0; f_skip = 1'b0; flush = 1'b0; d_ready = 1'b0;
      f_data = '0; f_pc = '0;
      step(); step();
      reset = 1'b0;
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_dvalid", 64'(d_valid), 64'd0);
      chk("rst_dctl", 64'(d_ctl), 64'd0);
      chk("rst_dill", 64'(d_illegal), 64'd0);
      chk("rst_fready", 64'(f_ready), 64'd1);

      // basic push then pop
      f_valid = 1'b1; f_data = {16'h0001, 16'h4501}; f_pc = 32'h100;
      step();
      f_valid = 1'b0;
      chk("basic_count", 64'(count), 64'd2);
      chk("basic_ins0", 64'(d_ins), 64'h4501);
      chk("basic_pc0", 64'(d_pc), 64'h100);
      chk("basic_ctl0", 64'(d_ctl), 64'd0);
      pop1();
      chk("basic_ins1", 64'(d_ins), 64'h0001);
      chk("basic_pc1", 64'(d_pc), 64'h102);
      chk("basic_count1", 64'(count), 64'd1);

      flush = 1'b1; step(); flush = 1'b0;
      chk("flush0_count", 64'(count), 64'd0);

      // fill, refuse, drain, simultaneous push/pop across wrap
      set_beat(0); step();
      set_beat(2); step();
      chk("full_count", 64'(count), 64'd4);
      chk("full_fready", 64'(f_ready), 64'd0);
      set_beat(4); step();
      chk("full_refuse", 64'(count), 64'd4);
      chk_head(0);
      d_ready = 1'b1;
      step();
      chk("pop1_count", 64'(count), 64'd3);
      chk("pop1_fready", 64'(f_ready), 64'd0);
      chk_head(1);
      step();
      chk("pop2_count", 64'(count), 64'd2);
      chk("pop2_fready", 64'(f_ready), 64'd1);
      chk_head(2);
      step();
      chk("pushpop_count", 64'(count), 64'd3);
      chk_head(3);
      set_beat(6); step();
      chk("pp2_count", 64'(count), 64'd2);
      chk_head(4);
      step();
      chk("pp3_count", 64'(count), 64'd3);
      chk_head(5);
      f_valid = 1'b0;
      for (int n = 6; n < 8; n++) begin
         step();
         chk_head(n);
      end
      step();
      d_ready = 1'b0;
      chk("drain_count", 64'(count), 64'd0);
      chk("drain_dvalid", 64'(d_valid), 64'd0);

      // skip parcel 0
      f_valid = 1'b1; f_skip = 1'b1; f_pc = 32'h200; f_data = {16'hA001, 16'hFFFF};
      step();
      f_valid = 1'b0; f_skip = 1'b0;
      chk("skip_count", 64'(count), 64'd1);
      chk("skip_ins", 64'(d_ins), 64'hA001);
      chk("skip_pc", 64'(d_pc), 64'h202);
      chk("skip_ctl", 64'(d_ctl), 64'd1);
      pop1();

      // pre-decode table
      for (int i = 0; i < 6; i += 2) begin
         f_valid = 1'b1; f_pc = 32'h400; f_data = {ctl_p[i+1], ctl_p[i]};
         step();
         f_valid = 1'b0;
         chk($sformatf("ctl_%h", ctl_p[i]), 64'(d_ctl), 64'(ctl_e[i]));
         pop1();
         chk($sformatf("ctl_%h", ctl_p[i+1]), 64'(d_ctl), 64'(ctl_e[i+1]));
         pop1();
      end

      // flush with push and pop pending at count 3
      set_beat(0); step();
      f_skip = 1'b1; step(); f_skip = 1'b0;
      chk("preflush_count", 64'(count), 64'd3);
      flush = 1'b1; d_ready = 1'b1; f_valid = 1'b1; f_data = {16'hBEEF, 16'hDEAD};
      step();
      flush = 1'b0; d_ready = 1'b0; f_valid = 1'b0;
      chk("flush_count", 64'(count), 64'd0);
      chk("flush_dvalid", 64'(d_valid), 64'd0);
      chk("flush_fready", 64'(f_ready), 64'd1);
      step();
      chk("flush_stay", 64'(count), 64'd0);

      // illegal parcel, then reset mid-stream
      f_valid = 1'b1; f_pc = 32'h500; f_data = {16'h1234, 16'h0000};
      step();
      f_valid = 1'b0;
      chk("ill_flag", 64'(d_illegal), 64'd1);
      chk("ill_ctl", 64'(d_ctl), 64'd0);
      chk("ill_count", 64'(count), 64'd2);
      reset = 1'b1; d_ready = 1'b1; f_valid = 1'b1;
      step();
      reset = 1'b0; d_ready = 1'b0; f_valid = 1'b0;
      chk("mrst_count", 64'(count), 64'd0);
      chk("mrst_dvalid", 64'(d_valid), 64'd0);
      chk("mrst_dill", 64'(d_illegal), 64'd0);
      chk("mrst_fready", 64'(f_ready), 64'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/decode_fq.md
DECODE_FQ -- requirements
Module: decode_fq

Interface
REQ-001 SHALL have parameter RV, default 32: address width in bits.
REQ-002 SHALL have parameter DEPTH, default 4: queue capacity in 16-bit parcels; power of two, DEPTH >= NP.
REQ-003 SHALL have parameter NP, default 2: parcels per fetch beat; legal values 1 or 2.
REQ-004 SHALL have port clk  in  1  single clock; all state changes on the rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port f_valid  in  1  fetch beat offered.
REQ-007 SHALL have port f_ready  out  1  queue accepts a beat this cycle.
REQ-008 SHALL have port f_data  in  16*NP  parcels; parcel k is f_data[16k+15:16k].
REQ-009 SHALL have port f_pc  in  RV  address of parcel 0; bit 0 is ignored.
REQ-010 SHALL have port f_skip  in  1  drop parcel 0 of this beat; ignored when NP=1.
REQ-011 SHALL have port flush  in  1  discard all queued parcels.
REQ-012 SHALL have port d_valid  out  1  head parcel available.
REQ-013 SHALL have port d_ready  in  1  decode consumes the head parcel.
REQ-014 SHALL have port d_ins  out  16  head parcel.
REQ-015 SHALL have port d_pc  out  RV  address of the head parcel.
REQ-016 SHALL have port d_ctl  out  1  head parcel is a control transfer (pre-decode).
REQ-017 SHALL have port d_illegal  out  1  head parcel is 16'h0000.
REQ-018 SHALL have port count  out  $clog2(DEPTH+1)  number of occupied entries.

Function
REQ-019 Storage SHALL be a circular buffer of DEPTH entries {ins[15:0], pc[RV-1:0]}; read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
REQ-020 f_ready SHALL be (DEPTH - count) >= NP, computed combinationally from registered count; it does not depend on d_ready.
REQ-021 A push SHALL occur when f_valid & f_ready & !flush. It writes parcel k with pc = {f_pc[RV-1:1],1'b0} + 2k, for k = 0..NP-1, in ascending pc order.
REQ-022 When NP=2 and f_skip=1, a push SHALL write only parcel 1, with pc = {f_pc[RV-1:1],1'b0} + 2, and add 1 to count.
REQ-023 d_valid SHALL be (count != 0). d_ins and d_pc SHALL come combinationally from the entry at the read pointer.
REQ-024 A pop SHALL occur when d_valid & d_ready & !flush. It advances the read pointer by 1.
REQ-025 A simultaneous push and pop SHALL both take effect; next count = count + pushed - popped.
REQ-026 A beat accepted at edge N SHALL be visible on d_* in the cycle after edge N (one-cycle latency) if the queue was empty.
REQ-027 When flush=1, the next edge SHALL set count to 0 and set both pointers equal. Any push or pop in that cycle is discarded.
REQ-028 d_ctl SHALL be 1 when the head parcel ins matches any of the following:
  - ins[1:0]=00 with ins[15:13] in {100,101};
  - ins[1:0]=01 with ins[15:13] in {001,101,110,111};
  - ins[1:0]=10 with ins[15:13]=100 and ins[6:2]=0;
  - ins[1:0]=11 with ins[15:14]=11.
  Otherwise d_ctl SHALL be 0.
REQ-029 d_ctl and d_illegal SHALL be 0 whenever d_valid=0. d_ins and d_pc are don't-care when d_valid=0.
REQ-030 Order SHALL be preserved: parcels pop in push order across pointer wrap.
REQ-031 Overflow and underflow SHALL be impossible. A push is never accepted with fewer than NP free slots, and a pop never occurs while empty.

Reset
REQ-032 While reset=1, the next edge SHALL set count=0 and both pointers to 0. As a result d_valid=0, d_ctl=0, d_illegal=0 and f_ready=1.
REQ-033 Reset SHALL take priority over flush, push and pop. Reset asserted mid-stream discards all contents with no partial pops.
REQ-034 Storage contents need not be reset.

Verification
REQ-035 Basic push/pop (DEPTH=4, NP=2): after reset, push f_data={16'h0001,16'h4501}, f_pc=32'h100, d_ready=0.
  -> Next cycle: count=2, d_ins=16'h4501, d_pc=32'h100, d_ctl=0.
  -> After one pop: d_ins=16'h0001, d_pc=32'h102.
REQ-036 Full: push two beats with d_ready=0.
  -> count=4, f_ready=0; a third f_valid is not accepted.
  -> With d_ready=1 for one cycle: count=3, f_ready stays 0.
  -> After a second pop: f_ready=1.
REQ-037 Simultaneous push/pop at count=2: push and pop in the same cycle.
  -> count=3; the pointers wrap past entry 3 with order intact over 8 sequential parcels.
REQ-038 Skip: f_skip=1, f_pc=32'h200, f_data={16'hA001,16'hFFFF}.
  -> count=1, d_ins=16'hA001, d_pc=32'h202, d_ctl=1.
REQ-039 Flush with push and pop pending: flush=1 while count=3, f_valid=1, d_ready=1.
  -> Next cycle: count=0, d_valid=0, f_ready=1, and nothing from that beat appears.
REQ-040 Illegal parcel and mid-stream reset: push parcel 16'h0000.
  -> d_illegal=1.
  -> Reset asserted while count=2 gives count=0 and d_valid=0 next cycle.
